acc_packer: RTL and testbench
=============================

# acc_packer

Output-side packer for the PE column. It accepts the 32-bit FP32 accumulator results streamed out of the bf_mac lanes and converts each to bf16. It packs four bf16 values into one 64-bit word with valid/ready handshakes on both sides. This is the write-direction counterpart of the PE input fifo, which unpacks 64-bit words into 16-bit operands; the packed words go back to the same 64-bit data path.

## Interface
- DATA_OUT_WIDTH, 64, packed output word width; fixed at NUM_LANES*16
- ACC_WIDTH, 32, accumulator (FP32) input width
- NUM_LANES, 4, bf16 slots per output word
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  packer accepts in_data this cycle
- in_data  input  ACC_WIDTH  FP32 accumulator result
- in_last  input  1  final element of a drain; forces flush of a partial word
- out_valid  output  1  out_data/out_keep/out_last valid
- out_ready  input  1  downstream accepts word
- out_data  output  DATA_OUT_WIDTH  packed bf16; lane 0 at [15:0], lane k at [16k+15:16k]
- out_keep  output  NUM_LANES  per-lane valid mask, contiguous from lane 0
- out_last  output  1  word ends the drain
- word_cnt  output  16  count of words handed off (out_valid & out_ready); wraps at 0xFFFF->0

## Operation
- Reset is asynchronous and active-high. It clears the pack register, lane count, out_valid, out_data, out_keep, out_last and word_cnt, all to 0. in_ready is 1 in the first cycle after reset.
- Accept condition: in_valid & in_ready. On accept, the conversion result is written to pack lane `cnt`. `cnt` is the lane count, 0..3.
- Word completes when the accept is at cnt==3 or carries in_last.
  - On completion, the pack register with the new lane moves to the output register.
  - out_keep gets bits 0..cnt set, and out_last = in_last.
  - Lanes above cnt are driven 0, cnt returns to 0, and the pack register clears.
- Without completion, cnt increments.
- in_ready = !out_valid | out_ready | (cnt<3 & !in_last). A non-completing accept is always allowed. A completing accept requires the output register to be free or draining this cycle.
- Output register holds out_* stable while out_valid & !out_ready. out_valid drops after handshake unless a new word loads in the same cycle.
- State is {cnt, out_valid}: EMPTY (0,0), FILLING (1..3,x), HOLD (x,1). Transitions follow from the rules above.
- FP32->bf16 conversion (combinational):
  - NaN (exp==0xFF, mant!=0) gives {sign,0x7FC0[14:0]} (quiet NaN).
  - ±inf passes through as {sign,0x7F80}.
  - Otherwise the value is rounded per Configuration. A rounding carry may propagate into the exponent, giving inf. Denormals are kept bit-exact, not flushed.
- in_last with in_valid low has no effect.

## Timing
- Completing accept in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one input per cycle with out_ready held 1. One word per 4 cycles, no bubbles.
- Simultaneous output handshake and completing accept: the new word replaces the old with no idle cycle, and out_valid stays 1.
- Backpressure: with out_ready=0 and the output register full, up to 3 further inputs are accepted. The 4th (or any in_last) stalls with in_ready=0.
- word_cnt updates in the cycle after each output handshake.

## Configuration
- ACC_PACKER_RNE_EN defined: round-to-nearest-even on the low 16 bits. The upper half increments if low>0x8000, or if low==0x8000 and bit16==1.
- Undefined: truncate, i.e. upper 16 bits only. NaN/inf handling is identical in both builds.

## Structure
- Shared package pe_pkg holds:
  - LANE_WIDTH=16, NUM_LANES, ACC_WIDTH
  - BF16_QNAN=16'h7FC0, BF16_INF=16'h7F80
  - typedef for the bf16 lane
- One sub-module: fp32_to_bf16, purely combinational. It holds the NaN/inf/rounding logic and the macro branch.
- acc_packer holds the lane counter, pack register, output register and handshake logic.

## Test plan
- Streaming, out_ready=1. Inputs 0x3F800000, 0x40000000, 0x40400000, 0x40800000 give out_data=0x4080_4040_4000_3F80, keep=0xF, last=0, and out_valid one cycle after the 4th accept.
- Rounding. Inputs 0x3F808000, 0x3F818000, 0x3F808001 give:
  - RNE build: 0x3F80, 0x3F82, 0x3F81
  - Truncate build: 0x3F80, 0x3F81, 0x3F80
- Partial flush. Two inputs 0x3F800000, 0xBF800000 with in_last on the 2nd give out_data=0x0000_0000_BF80_3F80, keep=0x3, last=1, and cnt back to 0.
- Backpressure. With out_ready=0 and 8 inputs offered, the first 4 form the held word and the next 3 are accepted. The 8th sees in_ready=0 until out_ready rises. Both words come out intact and in order, and word_cnt=2.
- Specials:
  - 0x7FC00001 gives 0x7FC0 and 0x7F800001 gives 0x7FC0.
  - 0xFF800000 gives 0xFF80.
  - 0x7F7FFFFF gives 0x7F80 with RNE and 0x7F7F with truncation.
- Reset mid-word. rst is pulsed asynchronously after 2 accepts; out_valid=0 and word_cnt=0 immediately. The next 4 inputs form a fresh word with no stale lanes.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE-column definitions: lane geometry and the bf16 constants used by the
// accumulator output path.
package pe_pkg;
    localparam int LANE_WIDTH = 16;
    localparam int NUM_LANES  = 4;
    localparam int ACC_WIDTH  = 32;

    localparam logic [LANE_WIDTH-1:0] BF16_QNAN = 16'h7FC0;
    localparam logic [LANE_WIDTH-1:0] BF16_INF  = 16'h7F80;

    typedef logic [LANE_WIDTH-1:0] bf16_t;
endpackage

// File: rtl/fp32_to_bf16.sv
// Combinational FP32 -> bf16: quiet NaN, inf passthrough, denormals kept bit-exact.
// Defining ACC_PACKER_RNE_EN selects round-to-nearest-even; otherwise the low half is truncated.
module fp32_to_bf16
    import pe_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] fp32,
    output bf16_t                bf16
);
    logic                  sign;
    logic [7:0]            exponent;
    logic                  mant_nz;
    logic [LANE_WIDTH-1:0] upper;

    assign sign     = fp32[31];
    assign exponent = fp32[30:23];
    assign mant_nz  = |fp32[22:0];
    assign upper    = fp32[31:16];

`ifdef ACC_PACKER_RNE_EN
    // Round up when the low half exceeds one half-ulp, or ties onto an odd upper half.
    logic round_up;
    assign round_up = fp32[15] && ((|fp32[14:0]) || fp32[16]);
`else
    logic unused_low;
    assign unused_low = ^fp32[15:0];
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        bf16 = upper;
        if (exponent == 8'hFF)
            bf16 = mant_nz ? {sign, BF16_QNAN[14:0]} : {sign, BF16_INF[14:0]};
`ifdef ACC_PACKER_RNE_EN
        else if (round_up)
            bf16 = upper + 16'd1;  // a carry out of the mantissa lands on inf by design
`endif
    end
endmodule

// File: rtl/acc_packer.sv
// Packs FP32 accumulator results into 64-bit words of four bf16 lanes with valid/ready on both sides.
// Rounding is chosen at build time by ACC_PACKER_RNE_EN (see fp32_to_bf16).
module acc_packer
    import pe_pkg::LANE_WIDTH, pe_pkg::bf16_t;
#(
    parameter int NUM_LANES      = pe_pkg::NUM_LANES,
    parameter int ACC_WIDTH      = pe_pkg::ACC_WIDTH,
    parameter int DATA_OUT_WIDTH = NUM_LANES * LANE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ACC_WIDTH-1:0]      in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_OUT_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]      out_keep,
    output logic                      out_last,
    output logic [15:0]               word_cnt
);
    localparam int               CNT_W     = $clog2(NUM_LANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    bf16_t [NUM_LANES-1:0]     pack_q, pack_d, pack_ins;
    bf16_t                     lane_bf16;
    logic                      out_valid_d, out_last_d;
    logic [DATA_OUT_WIDTH-1:0] out_data_d;
    logic [NUM_LANES-1:0]      out_keep_d;
    logic                      accept, complete, handshake;

    fp32_to_bf16 u_conv (
        .fp32 (in_data),
        .bf16 (lane_bf16)
    );

    // A non-completing accept never touches the output register, so it is always allowed.
    assign in_ready  = !out_valid || out_ready || (cnt_q != LAST_LANE && !in_last);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (cnt_q == LAST_LANE || in_last);
    assign handshake = out_valid && out_ready;

    always_comb begin
        pack_ins        = pack_q;
        pack_ins[cnt_q] = lane_bf16;
    end

    always_comb begin
        cnt_d       = cnt_q;
        pack_d      = pack_q;
        out_valid_d = out_valid && !out_ready;
        out_data_d  = out_data;
        out_keep_d  = out_keep;
        out_last_d  = out_last;
        if (complete) begin
            // Lanes above cnt are already zero because the pack register clears on every completion.
            out_valid_d = 1'b1;
            out_data_d  = pack_ins;
            out_last_d  = in_last;
            for (int i = 0; i < NUM_LANES; i++)
                out_keep_d[i] = (i <= int'(cnt_q));
            cnt_d  = '0;
            pack_d = '0;
        end else if (accept) begin
            pack_d = pack_ins;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            pack_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pack_q    <= pack_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_keep  <= out_keep_d;
            out_last  <= out_last_d;
            if (handshake)
                word_cnt <= word_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_acc_packer.sv
// Self-checking bench for acc_packer: directed scenarios plus randomized traffic
// scored against a lane-list reference model. Honors ACC_PACKER_RNE_EN like the RTL.
module tb_acc_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] word_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    word_t       got_q[$];
    logic [15:0] part_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

`ifdef ACC_PACKER_RNE_EN
    localparam logic [15:0] RND_A = 16'h3F80, RND_B = 16'h3F82, RND_C = 16'h3F81, OVF = 16'h7F80;
`else
    localparam logic [15:0] RND_A = 16'h3F80, RND_B = 16'h3F81, RND_C = 16'h3F80, OVF = 16'h7F7F;
`endif

    acc_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Output handshake happens at the next rising edge; inputs are stable across this falling edge.
    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            got_q.push_back({out_data, out_keep, out_last});

    function automatic logic [15:0] ref_bf16(input logic [31:0] f);
        logic [32:0] sum;
        if (f[30:23] == 8'hFF)
            return (f[22:0] != 23'd0) ? {f[31], 15'h7FC0} : {f[31], 15'h7F80};
`ifdef ACC_PACKER_RNE_EN
        sum = {1'b0, f} + 33'h7FFF + {32'd0, f[16]};
`else
        sum = {1'b0, f};
`endif
        return sum[31:16];
    endfunction

    task automatic model_push(input logic [31:0] d, input logic l);
        word_t w;
        part_q.push_back(ref_bf16(d));
        if (part_q.size() == 4 || l) begin
            w = '0;
            foreach (part_q[k]) begin
                w.data[16*k +: 16] = part_q[k];
                w.keep[k]          = 1'b1;
            end
            w.last = l;
            exp_q.push_back(w);
            part_q.delete();
        end
    endtask

    task automatic model_clear();
        part_q.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic drive_in(input logic [31:0] d, input logic l, output int stalls);
        bit ok;
        ok       = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                model_push(d, l);
                @(posedge clk);
                #1;
            end else begin
                stalls++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: data %h never accepted, required in_ready=1", d);
        end
    endtask

    task automatic drain_wait();
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_data, out_keep, out_last, word_cnt} !== 86'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b data=%h keep=%h last=%b wc=%0d, required all 0",
                     out_valid, out_data, out_keep, out_last, word_cnt);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        model_clear();
    endtask

    task automatic test_streaming();
        logic [31:0] vals[4];
        int          st;
        vals      = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_in(vals[i], 1'b0, st);
            if (i == 2) begin
                tests_run++;
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stream_early_valid: got %b, required 0", out_valid);
                end
            end
        end
        tests_run++;
        if ({out_valid, out_data, out_keep, out_last} !== {1'b1, 64'h4080_4040_4000_3F80, 4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL stream_word: valid=%b data=%h keep=%h last=%b, required 1/4080404040003f80/f/0",
                     out_valid, out_data, out_keep, out_last);
        end
        drain_wait();
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d words, required 1", got_q.size());
        end
        model_clear();
    endtask

    task automatic test_rounding();
        int st;
        out_ready = 1'b1;
        drive_in(32'h3F808000, 1'b0, st);
        drive_in(32'h3F818000, 1'b0, st);
        drive_in(32'h3F808001, 1'b1, st);
        tests_run++;
        if ({out_data, out_keep, out_last} !== {16'h0000, RND_C, RND_B, RND_A, 4'h7, 1'b1}) begin
            tests_failed++;
            $display("FAIL rounding: data=%h keep=%h last=%b, required %h%h%h%h/7/1",
                     out_data, out_keep, out_last, 16'h0000, RND_C, RND_B, RND_A);
        end
        drain_wait();
        model_clear();
    endtask

    task automatic test_specials();
        int st;
        out_ready = 1'b1;
        drive_in(32'h7FC00001, 1'b0, st);
        drive_in(32'h7F800001, 1'b0, st);
        drive_in(32'hFF800000, 1'b0, st);
        drive_in(32'h7F7FFFFF, 1'b0, st);
        tests_run++;
        if ({out_data, out_keep} !== {OVF, 16'hFF80, 16'h7FC0, 16'h7FC0, 4'hF}) begin
            tests_failed++;
            $display("FAIL specials: data=%h keep=%h, required %h%h%h%h/f",
                     out_data, out_keep, OVF, 16'hFF80, 16'h7FC0, 16'h7FC0);
        end
        drain_wait();
        model_clear();
    endtask

    task automatic test_partial_flush();
        int    st;
        word_t g, e;
        out_ready = 1'b1;
        drive_in(32'h3F800000, 1'b0, st);
        drive_in(32'hBF800000, 1'b1, st);
        tests_run++;
        if ({out_data, out_keep, out_last} !== {64'h0000_0000_BF80_3F80, 4'h3, 1'b1}) begin
            tests_failed++;
            $display("FAIL partial_word: data=%h keep=%h last=%b, required 00000000bf803f80/3/1",
                     out_data, out_keep, out_last);
        end
        // A full word right after the flush shows the lane count restarted at 0.
        for (int i = 0; i < 4; i++)
            drive_in($urandom, 1'b0, st);
        drain_wait();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL partial_count: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL partial_after: got %h/%h/%b, required %h/%h/%b",
                         g.data, g.keep, g.last, e.data, e.keep, e.last);
            end
        end
        model_clear();
    endtask

    task automatic test_backpressure();
        int          st, stall_sum;
        logic [31:0] v8;
        word_t       g, e;
        do_reset();
        out_ready = 1'b0;
        stall_sum = 0;
        for (int i = 0; i < 7; i++) begin
            drive_in($urandom, 1'b0, st);
            stall_sum += st;
        end
        tests_run++;
        if (stall_sum != 0) begin
            tests_failed++;
            $display("FAIL bp_early_stall: got %0d stall cycles, required 0", stall_sum);
        end
        v8       = $urandom;
        in_valid = 1'b1;
        in_data  = v8;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stall: cycle %0d in_ready=%b, required 0", c, in_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
        end
        model_push(v8, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_replace_valid: out_valid=%b, required 1", out_valid);
        end
        drain_wait();
        tests_run++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d words, required 2", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL bp_word: got %h/%h/%b, required %h/%h/%b",
                         g.data, g.keep, g.last, e.data, e.keep, e.last);
            end
        end
        tests_run++;
        if (word_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL bp_word_cnt: got %0d, required 2", word_cnt);
        end
        model_clear();
    endtask

    function automatic logic [31:0] rand_fp32();
        logic [31:0] d;
        d = $urandom;
        case ($urandom_range(0, 4))
            1: d[30:23] = 8'hFF;
            2: d[15:0]  = 16'h8000;
            3: begin d[30:23] = 8'hFF; d[22:0] = '0; end
            4: begin d[30:23] = 8'hFE; d[22:16] = 7'h7F; end
            default: ;
        endcase
        return d;
    endfunction

    task automatic test_back_to_back();
        int    st, stall_sum;
        word_t g, e;
        out_ready = 1'b1;
        stall_sum = 0;
        for (int i = 0; i < 40; i++) begin
            drive_in(rand_fp32(), 1'b0, st);
            stall_sum += st;
        end
        tests_run++;
        if (stall_sum != 0) begin
            tests_failed++;
            $display("FAIL b2b_stall: got %0d stall cycles, required 0", stall_sum);
        end
        drain_wait();
        tests_run++;
        if (got_q.size() != 10 || exp_q.size() != 10) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d words, required 10", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL b2b_word: got %h/%h/%b, required %h/%h/%b",
                         g.data, g.keep, g.last, e.data, e.keep, e.last);
            end
        end
        model_clear();
    endtask

    task automatic test_random();
        int    st;
        bit    done;
        word_t g, e;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++)
                    drive_in(rand_fp32(), ($urandom_range(0, 5) == 0), st);
                drive_in(rand_fp32(), 1'b1, st);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain_wait();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL rand_word: got %h/%h/%b, required %h/%h/%b",
                         g.data, g.keep, g.last, e.data, e.keep, e.last);
            end
        end
        model_clear();
    endtask

    task automatic test_reset_midword();
        int    st;
        word_t g, e;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            drive_in(32'hC0000000 | i, 1'b0, st);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, word_cnt} !== 17'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: out_valid=%b word_cnt=%0d, required 0/0", out_valid, word_cnt);
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            drive_in($urandom, 1'b0, st);
        drain_wait();
        tests_run++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            tests_failed++;
            $display("FAIL rst_mid_count: got %0d words, required 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL rst_mid_word: got %h/%h/%b, required %h/%h/%b",
                         g.data, g.keep, g.last, e.data, e.keep, e.last);
            end
        end
        tests_run++;
        if (word_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL rst_mid_word_cnt: got %0d, required 1", word_cnt);
        end
        model_clear();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_rounding();
        test_specials();
        test_partial_flush();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midword();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
